// File: rtl/drlp_pe_pkg.sv
// Shared widths, state encoding and config helpers for the PE sequencer.
package drlp_pe_pkg;

    localparam int PE_DATA_WIDTH         = 8;
    localparam int PE_NUM_MAC4           = 16;
    localparam int PE_TOTAL_INPUT_WIDTH  = PE_NUM_MAC4 * 4 * PE_DATA_WIDTH;
    localparam int PE_TOTAL_OUTPUT_WIDTH = PE_DATA_WIDTH * 2 + 6;
    localparam int PE_SLOT_WIDTH         = 5;
    localparam int PE_TILE_WIDTH         = 8;
    localparam int PE_RESULT_DEPTH       = 2;

    // Slots 29..31 of the PE cache belong to the NB partial sum and the
    // ACT A/B buffers, so partial-sum interleaving stops at 29.
    localparam logic [PE_SLOT_WIDTH-1:0] PSUM_SLOT_MAX = 5'd29;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [PE_TILE_WIDTH-1:0] num_tiles;
        logic [PE_SLOT_WIDTH-1:0] num_slots;
    } seq_cfg_t;

    // A zero tile count would never produce an output; run one tile instead.
    function automatic logic [PE_TILE_WIDTH-1:0] clamp_tiles(input logic [PE_TILE_WIDTH-1:0] n);
        return (n == '0) ? PE_TILE_WIDTH'(1) : n;
    endfunction

    // Keep the slot count inside the partial-sum region of the cache.
    function automatic logic [PE_SLOT_WIDTH-1:0] clamp_slots(input logic [PE_SLOT_WIDTH-1:0] n);
        if (n == '0)
            return PE_SLOT_WIDTH'(1);
        else if (n > PSUM_SLOT_MAX)
            return PSUM_SLOT_MAX;
        else
            return n;
    endfunction

endpackage

// File: rtl/pe_seq_out_fifo.sv
// Two-entry first-word-fall-through buffer of {slot, final sum} results.
module pe_seq_out_fifo
    import drlp_pe_pkg::*;
#(
    parameter int SUM_WIDTH  = PE_TOTAL_OUTPUT_WIDTH,
    parameter int SLOT_WIDTH = PE_SLOT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [SLOT_WIDTH-1:0] push_slot,
    input  logic [SUM_WIDTH-1:0]  push_sum,
    input  logic                  pop,
    output logic                  valid,
    output logic [SLOT_WIDTH-1:0] slot,
    output logic [SUM_WIDTH-1:0]  sum,
    output logic [1:0]            count
);

    logic [SLOT_WIDTH-1:0] slot_mem [PE_RESULT_DEPTH];
    logic [SUM_WIDTH-1:0]  sum_mem  [PE_RESULT_DEPTH];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    // A push into a full buffer is only taken when the head leaves in the same cycle.
    always_comb begin
        do_pop  = pop && (count != 2'd0);
        do_push = push && ((count != 2'd2) || do_pop);
    end

    // Storage, pointers and occupancy; push+pop together leaves the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PE_RESULT_DEPTH; i++) begin
                slot_mem[i] <= '0;
                sum_mem[i]  <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                slot_mem[wr_ptr] <= push_slot;
                sum_mem[wr_ptr]  <= push_sum;
                wr_ptr           <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Head of the queue is presented without waiting for a pop.
    always_comb begin
        valid = (count != 2'd0);
        slot  = slot_mem[rd_ptr];
        sum   = sum_mem[rd_ptr];
    end

endmodule

// File: rtl/pe_seq.sv
// Operand sequencer for one PE: streams (data, weights, bias) beats into the
// PE, interleaves partial sums across cache slots, and returns final totals.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | waiting for cfg_start; config latched on start
//   ST_CLEAR | one cycle of pe_cache_clear to wipe stale partial sums
//   ST_RUN   | accepting beats, slot index inner, tile index outer
//   ST_DRAIN | final beat taken; wait for pipeline and result buffer
module pe_seq
    import drlp_pe_pkg::*;
#(
    parameter int DATA_WIDTH         = PE_DATA_WIDTH,
    parameter int NUM_MAC4           = PE_NUM_MAC4,
    parameter int TOTAL_INPUT_WIDTH  = NUM_MAC4 * 4 * DATA_WIDTH,
    parameter int TOTAL_OUTPUT_WIDTH = DATA_WIDTH * 2 + 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_start,
    input  logic [PE_TILE_WIDTH-1:0]      cfg_num_tiles,
    input  logic [PE_SLOT_WIDTH-1:0]      cfg_num_slots,
    output logic                          cfg_busy,
    output logic                          cfg_done,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [TOTAL_INPUT_WIDTH-1:0]  in_data,
    input  logic [TOTAL_INPUT_WIDTH-1:0]  in_weights,
    input  logic [DATA_WIDTH-1:0]         in_bias,
    output logic [TOTAL_INPUT_WIDTH-1:0]  pe_data,
    output logic [TOTAL_INPUT_WIDTH-1:0]  pe_weights,
    output logic [DATA_WIDTH-1:0]         pe_bias,
    output logic [PE_SLOT_WIDTH-1:0]      pe_cache_rd_addr,
    output logic [PE_SLOT_WIDTH-1:0]      pe_cache_wr_addr,
    output logic                          pe_cache_wr_en,
    output logic                          pe_done,
    output logic                          pe_cache_clear,
    input  logic [TOTAL_OUTPUT_WIDTH-1:0] pe_total_sum,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [TOTAL_OUTPUT_WIDTH-1:0] out_sum,
    output logic [PE_SLOT_WIDTH-1:0]      out_slot
);

    seq_state_t               state;
    seq_state_t               state_next;
    seq_cfg_t                 cfg;
    logic [PE_TILE_WIDTH-1:0] tile_idx;
    logic [PE_SLOT_WIDTH-1:0] slot_idx;
    logic                     at_last_tile;
    logic                     at_last_slot;
    logic                     beat_fire;
    logic                     final_fire;
    logic                     issue_valid;
    logic                     issue_last;
    logic                     pipe_empty;
    logic                     fifo_push;
    logic                     fifo_empty;
    logic [1:0]               fifo_count;
    logic [2:0]               result_load;
    logic                     result_backpressure;

    // Position of the next beat and how many final results are already committed.
    always_comb begin
        at_last_tile = (tile_idx == cfg.num_tiles - PE_TILE_WIDTH'(1));
        at_last_slot = (slot_idx == cfg.num_slots - PE_SLOT_WIDTH'(1));
        pipe_empty   = !issue_valid && !pe_cache_wr_en;
        fifo_empty   = (fifo_count == 2'd0);
        fifo_push    = pe_cache_wr_en && pe_done;
        // Last-tile beats in issue or writeback will each land in the buffer,
        // so they count against its two entries before they arrive.
        result_load  = {1'b0, fifo_count}
                     + {2'b00, (issue_valid && issue_last)}
                     + {2'b00, pe_done};
        result_backpressure = at_last_tile && (result_load >= 3'd2);
        beat_fire    = in_valid && in_ready;
        final_fire   = beat_fire && at_last_tile && at_last_slot;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (cfg_start) state_next = ST_CLEAR;
            ST_CLEAR: state_next = ST_RUN;
            ST_RUN:   if (final_fire) state_next = ST_DRAIN;
            ST_DRAIN: if (pipe_empty && fifo_empty) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        cfg_busy       = 1'b0;
        cfg_done       = 1'b0;
        in_ready       = 1'b0;
        pe_cache_clear = 1'b0;
        case (state)
            ST_IDLE:  ;
            ST_CLEAR: begin
                cfg_busy       = 1'b1;
                pe_cache_clear = 1'b1;
            end
            ST_RUN: begin
                cfg_busy = 1'b1;
                in_ready = !result_backpressure;
            end
            ST_DRAIN: begin
                cfg_busy = 1'b1;
                cfg_done = pipe_empty && fifo_empty;
            end
            default: ;
        endcase
    end

    // Latch clamped config on start and walk (tile, slot) as beats are accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg      <= '0;
            tile_idx <= '0;
            slot_idx <= '0;
        end else if ((state == ST_IDLE) && cfg_start) begin
            cfg.num_tiles <= clamp_tiles(cfg_num_tiles);
            cfg.num_slots <= clamp_slots(cfg_num_slots);
            tile_idx      <= '0;
            slot_idx      <= '0;
        end else if (beat_fire) begin
            if (at_last_slot) begin
                slot_idx <= '0;
                tile_idx <= at_last_tile ? '0 : tile_idx + PE_TILE_WIDTH'(1);
            end else begin
                slot_idx <= slot_idx + PE_SLOT_WIDTH'(1);
            end
        end
    end

    // Issue stage: operands held in registers for the PE; bias only on tile 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pe_data          <= '0;
            pe_weights       <= '0;
            pe_bias          <= '0;
            pe_cache_rd_addr <= '0;
            issue_valid      <= 1'b0;
            issue_last       <= 1'b0;
        end else begin
            issue_valid <= beat_fire;
            if (beat_fire) begin
                pe_data          <= in_data;
                pe_weights       <= in_weights;
                pe_bias          <= (tile_idx == '0) ? in_bias : '0;
                pe_cache_rd_addr <= slot_idx;
                issue_last       <= at_last_tile;
            end
        end
    end

    // Writeback stage: store the PE total back to its slot, zeroing on the last tile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pe_cache_wr_en   <= 1'b0;
            pe_done          <= 1'b0;
            pe_cache_wr_addr <= '0;
        end else begin
            pe_cache_wr_en <= issue_valid;
            pe_done        <= issue_valid && issue_last;
            if (issue_valid)
                pe_cache_wr_addr <= pe_cache_rd_addr;
        end
    end

    pe_seq_out_fifo #(
        .SUM_WIDTH  (TOTAL_OUTPUT_WIDTH),
        .SLOT_WIDTH (PE_SLOT_WIDTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_slot (pe_cache_wr_addr),
        .push_sum  (pe_total_sum),
        .pop       (out_ready),
        .valid     (out_valid),
        .slot      (out_slot),
        .sum       (out_sum),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_pe_seq.sv
// Bench for pe_seq: behavioural PE with negedge-written cache, directed and
// randomized runs, results compared against per-slot sums built from the beats.
module tb_pe_seq;
    import drlp_pe_pkg::*;

    localparam int DW    = 8;
    localparam int IW    = 512;
    localparam int OW    = 22;
    localparam int LANES = IW / DW;

    typedef struct packed {
        logic [4:0]    slot;
        logic [OW-1:0] sum;
    } res_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_start;
    logic [7:0]    cfg_num_tiles;
    logic [4:0]    cfg_num_slots;
    logic          cfg_busy, cfg_done;
    logic          in_valid, in_ready;
    logic [IW-1:0] in_data, in_weights;
    logic [DW-1:0] in_bias;
    logic [IW-1:0] pe_data, pe_weights;
    logic [DW-1:0] pe_bias;
    logic [4:0]    pe_cache_rd_addr, pe_cache_wr_addr;
    logic          pe_cache_wr_en, pe_done, pe_cache_clear;
    logic [OW-1:0] pe_total_sum;
    logic          out_valid, out_ready;
    logic [OW-1:0] out_sum;
    logic [4:0]    out_slot;
    logic          scramble;

    int n_checks = 0;
    int n_errors = 0;

    pe_seq dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_start        (cfg_start),
        .cfg_num_tiles    (cfg_num_tiles),
        .cfg_num_slots    (cfg_num_slots),
        .cfg_busy         (cfg_busy),
        .cfg_done         (cfg_done),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .in_weights       (in_weights),
        .in_bias          (in_bias),
        .pe_data          (pe_data),
        .pe_weights       (pe_weights),
        .pe_bias          (pe_bias),
        .pe_cache_rd_addr (pe_cache_rd_addr),
        .pe_cache_wr_addr (pe_cache_wr_addr),
        .pe_cache_wr_en   (pe_cache_wr_en),
        .pe_done          (pe_done),
        .pe_cache_clear   (pe_cache_clear),
        .pe_total_sum     (pe_total_sum),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_sum          (out_sum),
        .out_slot         (out_slot)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] bias_ext(input logic [DW-1:0] b);
        return {{(OW-DW){b[DW-1]}}, b};
    endfunction

    function automatic logic [OW-1:0] dot(input logic [IW-1:0] d, input logic [IW-1:0] w);
        int acc;
        logic signed [DW-1:0] a, b;
        acc = 0;
        for (int i = 0; i < LANES; i++) begin
            a = d[i*DW +: DW];
            b = w[i*DW +: DW];
            acc += int'(a) * int'(b);
        end
        return acc[OW-1:0];
    endfunction

    // Behavioural PE: total registered on posedge, cache written on negedge.
    logic [OW-1:0] pe_cache [32];

    always @(posedge clk)
        pe_total_sum <= pe_cache[pe_cache_rd_addr] + dot(pe_data, pe_weights) + bias_ext(pe_bias);

    always @(negedge clk) begin
        if (scramble) begin
            for (int i = 0; i < 32; i++) pe_cache[i] <= OW'($urandom);
        end else if (pe_cache_clear) begin
            for (int i = 0; i < 32; i++) pe_cache[i] <= '0;
        end else if (pe_cache_wr_en) begin
            pe_cache[pe_cache_wr_addr] <= pe_done ? '0 : pe_total_sum;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // pat: 0 all-ones/bias 5, 1 slot0 data 2 / slot1 data -1, 2 random
    // vmode: 0 valid every cycle, 1 random gaps
    // rmode: 0 ready always, 1 random, 2 held low for 20 cycles
    task automatic run(input string name, input int tiles_raw, input int slots_raw,
                       input int pat, input int vmode, input int rmode,
                       input int abort_after, input bit poke_start);
        int            te, se, nbeats, sent, got, last_pop, done_cyc;
        bit            fire, finished;
        logic [IW-1:0] dq[$];
        logic [IW-1:0] wq[$];
        logic [DW-1:0] bq[$];
        res_t          exp_q[$];
        res_t          e;
        logic [OW-1:0] acc_s [32];
        logic [IW-1:0] d, w;
        logic [DW-1:0] b;

        te = (tiles_raw == 0) ? 1 : tiles_raw;
        se = (slots_raw == 0) ? 1 : ((slots_raw > 29) ? 29 : slots_raw);
        nbeats = te * se;

        for (int t = 0; t < te; t++) begin
            for (int s = 0; s < se; s++) begin
                if (pat == 0) begin
                    d = {LANES{8'h01}};
                    w = {LANES{8'h01}};
                    b = 8'd5;
                end else if (pat == 1) begin
                    d = (s == 0) ? {LANES{8'h02}} : {LANES{8'hFF}};
                    w = {LANES{8'h01}};
                    b = 8'd0;
                end else begin
                    for (int j = 0; j < IW/32; j++) begin
                        d[j*32 +: 32] = $urandom;
                        w[j*32 +: 32] = $urandom;
                    end
                    b = DW'($urandom_range(0, 255));
                end
                dq.push_back(d);
                wq.push_back(w);
                bq.push_back(b);
                acc_s[s] = ((t == 0) ? bias_ext(b) : acc_s[s]) + dot(d, w);
            end
        end
        for (int s = 0; s < se; s++) begin
            e.slot = 5'(s);
            e.sum  = acc_s[s];
            exp_q.push_back(e);
        end

        @(negedge clk);
        cfg_num_tiles = tiles_raw[7:0];
        cfg_num_slots = slots_raw[4:0];
        cfg_start     = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        #1;
        check({name, " busy_after_start"}, 64'(cfg_busy), 64'd1);
        check({name, " clear_pulse"}, 64'(pe_cache_clear), 64'd1);

        sent = 0; got = 0; last_pop = -10; done_cyc = -1;
        fire = 1'b0; finished = 1'b0;

        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(negedge clk);
            #1;
            if (abort_after > 0 && sent >= abort_after) begin
                in_valid = 1'b0;
                rst = 1'b1;
                #1;
                check({name, " rst_in_ready"}, 64'(in_ready), 64'd0);
                check({name, " rst_busy"}, 64'(cfg_busy), 64'd0);
                check({name, " rst_out_valid"}, 64'(out_valid), 64'd0);
                check({name, " rst_wr_en"}, 64'(pe_cache_wr_en), 64'd0);
                check({name, " rst_pe_data"}, 64'(pe_data[63:0]), 64'd0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (cfg_done) begin
                done_cyc = cyc;
                check({name, " done_after_pop"}, 64'(cyc), 64'(last_pop + 1));
                finished = 1'b1;
            end
            if (poke_start) begin
                if (cyc == 3) begin
                    cfg_num_tiles = 8'd7;
                    cfg_num_slots = 5'd3;
                    cfg_start     = 1'b1;
                end else begin
                    cfg_start = 1'b0;
                end
            end
            if (fire) in_valid = 1'b0;
            fire = 1'b0;
            if (!in_valid && sent < nbeats && (vmode == 0 || $urandom_range(0, 2) != 0)) begin
                in_valid   = 1'b1;
                in_data    = dq[sent];
                in_weights = wq[sent];
                in_bias    = bq[sent];
            end
            if (in_valid && in_ready) begin
                fire = 1'b1;
                sent++;
            end

            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (cyc >= 20);
            endcase
            if (rmode == 2 && cyc == 20) begin
                check({name, " stalled_in_ready"}, 64'(in_ready), 64'd0);
                check({name, " stalled_out_valid"}, 64'(out_valid), 64'd1);
                check({name, " stalled_beats"}, 64'(sent), 64'd2);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check({name, " extra_result"}, 64'(got + 1), 64'(nbeats / te));
                end else begin
                    e = exp_q.pop_front();
                    check({name, " slot"}, 64'(out_slot), 64'(e.slot));
                    check({name, " sum"}, 64'(out_sum), 64'(e.sum));
                    if (pat == 0)
                        check({name, " sum_197"}, 64'(out_sum), 64'd197);
                    if (pat == 1)
                        check({name, " sum_lit"}, 64'(out_sum),
                              (e.slot == 5'd0) ? 64'd256 : 64'h3FFF80);
                end
                got++;
                last_pop = cyc;
            end
        end

        in_valid  = 1'b0;
        out_ready = 1'b0;
        cfg_start = 1'b0;
        check({name, " results"}, 64'(got), 64'(se));
        check({name, " done_seen"}, 64'(done_cyc >= 0), 64'd1);
        @(negedge clk);
        #1;
        check({name, " idle_busy"}, 64'(cfg_busy), 64'd0);
        check({name, " idle_done"}, 64'(cfg_done), 64'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        scramble      = 1'b1;
        cfg_start     = 1'b0;
        cfg_num_tiles = '0;
        cfg_num_slots = '0;
        in_valid      = 1'b0;
        in_data       = '0;
        in_weights    = '0;
        in_bias       = '0;
        out_ready     = 1'b0;
        repeat (2) @(negedge clk);
        scramble = 1'b0;
        #1;
        check("reset busy", 64'(cfg_busy), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd0);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset clear", 64'(pe_cache_clear), 64'd0);
        check("reset out_sum", 64'(out_sum), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run("t1_single", 3, 1, 0, 0, 0, 0, 1'b0);
        run("t2_two_slots", 2, 2, 1, 1, 1, 0, 1'b0);
        run("t3_backpressure", 1, 4, 2, 0, 2, 0, 1'b0);
        run("t4_clamp", 0, 31, 2, 1, 1, 0, 1'b0);
        run("t5_first", 3, 1, 0, 0, 0, 0, 1'b1);
        run("t5_second", 3, 1, 0, 0, 0, 0, 1'b0);
        run("t6_abort", 3, 1, 0, 0, 0, 2, 1'b0);
        run("t6_after_reset", 3, 1, 0, 0, 0, 0, 1'b0);
        for (int k = 0; k < 6; k++)
            run("rnd", $urandom_range(0, 4), $urandom_range(0, 31), 2, 1, 1, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
